rf_wb_scheduler: RTL and testbench

- Shares the single register-file write port between two writeback requesters: ALU result and memory load.
- Keeps a 16-entry busy scoreboard of destination registers reserved at issue, and flags read hazards on the two read addresses.
- Sits between the execute/memory stages and the register file write inputs (write enable, destination address, write data).

---
 rtl/rf_wb_scheduler.sv | 117 +++++++++++
 tb/tb_rf_wb_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
//
// Shares the single register-file write port between the ALU writeback and
// the memory-load writeback. It also keeps a busy scoreboard of destination
// registers reserved at issue and flags read hazards.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   alu_valid/alu_rd/alu_data    ALU writeback request; alu_ready = granted
//   mem_valid/mem_rd/mem_data    load writeback request; mem_ready = granted
//   rsv_valid/rsv_rd             issue-stage reservation; rsv_stall = rd busy
//   rs, rt                       read addresses; hazard = either one is busy
//   rf_wr/rf_rd/rf_wdata         registered register-file write port
//   busy                         scoreboard, bit i = register i has a pending write
//   err                          sticky protocol-violation flag
module rf_wb_scheduler #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    output logic            rsv_stall,
    input  logic [AW-1:0]   rs,
    input  logic [AW-1:0]   rt,
    output logic            hazard,
    output logic            rf_wr,
    output logic [AW-1:0]   rf_rd,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy,
    output logic            err
);

    // Round-robin pointer: which requester wins the next contested cycle.
    typedef enum logic {PRI_ALU, PRI_MEM} pri_t;

    pri_t            pri_q;
    logic            grant;
    logic [AW-1:0]   win_rd;
    logic [DW-1:0]   win_data;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            viol;

    // Arbitration and scoreboard update masks.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        set_mask  = '0;
        clr_mask  = '0;

        // No grants while reset is held; requesters re-present afterwards.
        if (!rst) begin
            alu_ready = alu_valid && (!mem_valid || pri_q == PRI_ALU);
            mem_ready = mem_valid && (!alu_valid || pri_q == PRI_MEM);
        end

        grant    = alu_ready || mem_ready;
        win_rd   = alu_ready ? alu_rd   : mem_rd;
        win_data = alu_ready ? alu_data : mem_data;

        // A reservation of an already-busy register is dropped, not queued.
        if (rsv_valid && !busy[rsv_rd])
            set_mask[rsv_rd] = 1'b1;
        // The write leaving the output stage this edge retires its register.
        if (rf_wr)
            clr_mask[rf_rd] = 1'b1;

        // WAW reservation, or a writeback to a register nobody reserved.
        viol = (rsv_valid && busy[rsv_rd]) || (grant && !busy[win_rd]);
    end

    // Both reflect the current scoreboard only; a same-edge clear is not
    // anticipated, so stalls and hazards are conservative by one cycle.
    assign rsv_stall = busy[rsv_rd];
    assign hazard    = busy[rs] | busy[rt];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q    <= PRI_ALU;
            rf_wr    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            busy     <= '0;
            err      <= 1'b0;
        end else begin
            // Pointer moves only when both competed; the loser wins next time.
            if (alu_valid && mem_valid)
                pri_q <= (pri_q == PRI_ALU) ? PRI_MEM : PRI_ALU;

            rf_wr <= grant;
            if (grant) begin
                rf_rd    <= win_rd;
                rf_wdata <= win_data;
            end

            // Set is applied after clear, so a same-index collision stays busy.
            busy <= (busy & ~clr_mask) | set_mask;

            if (viol)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: a table of per-cycle vectors for
// single writes and contention, plus hand-written sequences for set/clear
// collisions, reset mid-stream, unreserved writes and the hazard decode.
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, rsv_valid;
    logic [3:0]  alu_rd, mem_rd, rsv_rd, rs, rt;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rsv_stall, hazard, rf_wr, err;
    logic [3:0]  rf_rd;
    logic [15:0] rf_wdata, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler #(.NREG(16), .AW(4), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_stall(rsv_stall),
        .rs(rs), .rt(rt), .hazard(hazard),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic        rsv_v;
        logic [3:0]  rsv_rd;
        logic        alu_v;
        logic [3:0]  alu_rd;
        logic [15:0] alu_d;
        logic        mem_v;
        logic [3:0]  mem_rd;
        logic [15:0] mem_d;
        logic [3:0]  rs;
        // expected before the edge (combinational)
        logic        e_alu_rdy;
        logic        e_mem_rdy;
        logic        e_stall;
        logic        e_haz;
        // expected after the edge (registered)
        logic        e_wr;
        logic [3:0]  e_rd;
        logic [15:0] e_wd;
        logic [15:0] e_busy;
        logic        e_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rv, input logic [3:0] rrd,
        input logic av, input logic [3:0] ard, input logic [15:0] ad,
        input logic mv, input logic [3:0] mrd, input logic [15:0] md,
        input logic [3:0] r_s,
        input logic ear, input logic emr, input logic est, input logic ehz,
        input logic ewr, input logic [3:0] erd, input logic [15:0] ewd,
        input logic [15:0] ebusy, input logic eerr);
        vec_t v;
        v.rsv_v = rv;  v.rsv_rd = rrd;
        v.alu_v = av;  v.alu_rd = ard; v.alu_d = ad;
        v.mem_v = mv;  v.mem_rd = mrd; v.mem_d = md;
        v.rs = r_s;
        v.e_alu_rdy = ear; v.e_mem_rdy = emr; v.e_stall = est; v.e_haz = ehz;
        v.e_wr = ewr; v.e_rd = erd; v.e_wd = ewd; v.e_busy = ebusy; v.e_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; mem_valid = 1'b0; rsv_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; rsv_rd = '0;
        alu_data = '0; mem_data = '0;
        rs = '0; rt = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rsv      alu               mem               rs  | ar mr st hz | wr rd  wdata     busy      err
        vecs[0]  = mk(1, 5,   0, 0, 16'h0,      0, 0, 16'h0,      5,    0, 0, 0, 0,  0, 0, 16'h0000, 16'h0020, 0);
        vecs[1]  = mk(0, 0,   1, 5, 16'hBEEF,   0, 0, 16'h0,      5,    1, 0, 0, 1,  1, 5, 16'hBEEF, 16'h0020, 0);
        vecs[2]  = mk(0, 0,   0, 0, 16'h0,      0, 0, 16'h0,      5,    0, 0, 0, 1,  0, 5, 16'hBEEF, 16'h0000, 0);
        vecs[3]  = mk(0, 0,   0, 0, 16'h0,      0, 0, 16'h0,      5,    0, 0, 0, 0,  0, 5, 16'hBEEF, 16'h0000, 0);
        vecs[4]  = mk(1, 1,   0, 0, 16'h0,      0, 0, 16'h0,      0,    0, 0, 0, 0,  0, 5, 16'hBEEF, 16'h0002, 0);
        vecs[5]  = mk(1, 2,   0, 0, 16'h0,      0, 0, 16'h0,      0,    0, 0, 0, 0,  0, 5, 16'hBEEF, 16'h0006, 0);
        vecs[6]  = mk(1, 3,   0, 0, 16'h0,      0, 0, 16'h0,      0,    0, 0, 0, 0,  0, 5, 16'hBEEF, 16'h000E, 0);
        vecs[7]  = mk(1, 4,   0, 0, 16'h0,      0, 0, 16'h0,      0,    0, 0, 0, 0,  0, 5, 16'hBEEF, 16'h001E, 0);
        vecs[8]  = mk(1, 6,   0, 0, 16'h0,      0, 0, 16'h0,      0,    0, 0, 0, 0,  0, 5, 16'hBEEF, 16'h005E, 0);
        // contention: ALU, MEM, ALU, MEM
        vecs[9]  = mk(0, 0,   1, 1, 16'h1111,   1, 2, 16'h2222,   0,    1, 0, 0, 0,  1, 1, 16'h1111, 16'h005E, 0);
        vecs[10] = mk(0, 0,   1, 3, 16'h3333,   1, 2, 16'h2222,   0,    0, 1, 0, 0,  1, 2, 16'h2222, 16'h005C, 0);
        vecs[11] = mk(0, 0,   1, 3, 16'h3333,   1, 4, 16'h4444,   0,    1, 0, 0, 0,  1, 3, 16'h3333, 16'h0058, 0);
        vecs[12] = mk(0, 0,   1, 6, 16'h6666,   1, 4, 16'h4444,   0,    0, 1, 0, 0,  1, 4, 16'h4444, 16'h0050, 0);
        vecs[13] = mk(0, 0,   1, 6, 16'h6666,   0, 0, 16'h0,      0,    1, 0, 0, 0,  1, 6, 16'h6666, 16'h0040, 0);
        vecs[14] = mk(0, 0,   0, 0, 16'h0,      0, 0, 16'h0,      0,    0, 0, 0, 0,  0, 6, 16'h6666, 16'h0000, 0);

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset rf_wr",    {31'd0, rf_wr},    32'd0);
        check("reset rf_rd",    {28'd0, rf_rd},    32'd0);
        check("reset rf_wdata", {16'd0, rf_wdata}, 32'd0);
        check("reset busy",     {16'd0, busy},     32'd0);
        check("reset err",      {31'd0, err},      32'd0);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            rsv_valid = vecs[i].rsv_v; rsv_rd = vecs[i].rsv_rd;
            alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_d;
            mem_valid = vecs[i].mem_v; mem_rd = vecs[i].mem_rd; mem_data = vecs[i].mem_d;
            rs = vecs[i].rs; rt = 4'd0;
            #1;
            check($sformatf("v%0d alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_alu_rdy});
            check($sformatf("v%0d mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].e_mem_rdy});
            check($sformatf("v%0d rsv_stall", i), {31'd0, rsv_stall}, {31'd0, vecs[i].e_stall});
            check($sformatf("v%0d hazard", i),    {31'd0, hazard},    {31'd0, vecs[i].e_haz});
            step();
            check($sformatf("v%0d rf_wr", i),    {31'd0, rf_wr},    {31'd0, vecs[i].e_wr});
            check($sformatf("v%0d rf_rd", i),    {28'd0, rf_rd},    {28'd0, vecs[i].e_rd});
            check($sformatf("v%0d rf_wdata", i), {16'd0, rf_wdata}, {16'd0, vecs[i].e_wd});
            check($sformatf("v%0d busy", i),     {16'd0, busy},     {16'd0, vecs[i].e_busy});
            check($sformatf("v%0d err", i),      {31'd0, err},      {31'd0, vecs[i].e_err});
        end
        idle();

        // ---------------- set/clear collision, busy[3]=1 ----------------
        rsv_valid = 1'b1; rsv_rd = 4'd3;
        step();
        rsv_valid = 1'b0;
        check("col1 busy reserved", {16'd0, busy}, 32'h0008);
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h0033;
        #1;
        check("col1 alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        check("col1 rf_wr", {31'd0, rf_wr}, 32'd1);
        check("col1 rf_rd", {28'd0, rf_rd}, 32'd3);
        check("col1 err before", {31'd0, err}, 32'd0);
        rsv_valid = 1'b1; rsv_rd = 4'd3;
        #1;
        check("col1 rsv_stall", {31'd0, rsv_stall}, 32'd1);
        step();
        rsv_valid = 1'b0;
        check("col1 busy dropped", {16'd0, busy}, 32'h0000);
        check("col1 err", {31'd0, err}, 32'd1);

        // ---------------- set/clear collision, busy[3]=0 ----------------
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h0034;
        step();
        alu_valid = 1'b0;
        check("col2 rf_wr", {31'd0, rf_wr}, 32'd1);
        check("col2 rf_wdata", {16'd0, rf_wdata}, 32'h0034);
        rsv_valid = 1'b1; rsv_rd = 4'd3;
        #1;
        check("col2 rsv_stall", {31'd0, rsv_stall}, 32'd0);
        step();
        rsv_valid = 1'b0;
        check("col2 set wins", {16'd0, busy}, 32'h0008);

        // ---------------- reset mid-stream ----------------
        alu_valid = 1'b1; alu_rd = 4'd8; alu_data = 16'h0088;
        mem_valid = 1'b1; mem_rd = 4'd9; mem_data = 16'h0099;
        step();
        check("pre-rst rf_wr", {31'd0, rf_wr}, 32'd1);
        check("pre-rst rf_rd", {28'd0, rf_rd}, 32'd8);
        #2;
        rst = 1'b1;
        #1;
        check("rst rf_wr",     {31'd0, rf_wr},     32'd0);
        check("rst busy",      {16'd0, busy},      32'd0);
        check("rst err",       {31'd0, err},       32'd0);
        check("rst alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst mem_ready", {31'd0, mem_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("post-rst alu_ready", {31'd0, alu_ready}, 32'd1);
        check("post-rst mem_ready", {31'd0, mem_ready}, 32'd0);
        idle();

        // ---------------- unreserved write ----------------
        mem_valid = 1'b1; mem_rd = 4'd9; mem_data = 16'h9999;
        #1;
        check("unrsv mem_ready", {31'd0, mem_ready}, 32'd1);
        step();
        idle();
        check("unrsv rf_wr",    {31'd0, rf_wr},    32'd1);
        check("unrsv rf_rd",    {28'd0, rf_rd},    32'd9);
        check("unrsv rf_wdata", {16'd0, rf_wdata}, 32'h9999);
        check("unrsv err",      {31'd0, err},      32'd1);
        check("unrsv busy",     {16'd0, busy},     32'd0);

        // ---------------- hazard decode sweep ----------------
        rsv_valid = 1'b1; rsv_rd = 4'd1;
        step();
        rsv_rd = 4'd15;
        step();
        idle();
        check("haz busy", {16'd0, busy}, 32'h8002);
        for (int i = 0; i < 16; i++) begin
            rs = 4'(i); rt = 4'd0;
            #1;
            check($sformatf("haz rs=%0d", i), {31'd0, hazard}, {31'd0, (i == 1 || i == 15)});
        end
        for (int i = 0; i < 16; i++) begin
            rs = 4'd0; rt = 4'(i);
            #1;
            check($sformatf("haz rt=%0d", i), {31'd0, hazard}, {31'd0, (i == 1 || i == 15)});
        end
        rs = 4'd1; rt = 4'd15;
        #1;
        check("haz rs=1 rt=15", {31'd0, hazard}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
